// File: rtl/cnn_pkg.sv
// Shared CNN definitions: drain FSM states, default memory geometry and
// the polarity of the active-low SRAM control pins.
package cnn_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 64;

  // SRAM chip/write enables are active-low.
  localparam logic MEM_ACTIVE   = 1'b0;
  localparam logic MEM_INACTIVE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; DEPTH must be a power of two
// so the pointers wrap naturally.
module sync_fifo #(
  parameter  int WIDTH = 65,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [PW:0]      count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage is reset so the head reads as zero while empty; this is
  // only affordable because the array is a handful of flops, not a RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/outmem_reader.sv
// Drains the CNN output memory via port B into a credit-managed skid FIFO and
// streams words over valid/ready. Define OUTMEM_READER_CSUM_EN to add out_csum.
module outmem_reader
  import cnn_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  mem_cen,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
`ifdef OUTMEM_READER_CSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] out_csum
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] start_addr_q;
  logic [ADDR_WIDTH:0]   num_q;
  logic [ADDR_WIDTH:0]   issued_q;
  logic                  busy_q;
  logic                  done_q;

  // Read pipeline: stage 1 is the address on the pins, stage 2 is mem_q valid.
  logic                  mem_cen_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  rd_last_q;
  logic                  pend_q;
  logic                  pend_last_q;
  logic [1:0]            inflight_q;

  logic                  issue;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic                  issue_last;
  logic                  accept;
  logic                  zero_start;
  logic                  finish;
  logic                  credit_ok;

  logic [DATA_WIDTH:0]   fifo_rdata;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic                  head_last;

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pend_q),
    .wdata ({pend_last_q, mem_q}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign {head_last, out_data} = fifo_rdata;
  assign out_valid = !fifo_empty;
  assign out_last  = head_last;
  assign pop       = out_valid && out_ready;

  // Credit uses registered occupancy only: a pop this cycle frees a slot next cycle.
  assign credit_ok = !fifo_full &&
                     ((int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH);

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    issue_addr = mem_addr_q;
    issue_last = 1'b0;
    accept     = 1'b0;
    zero_start = 1'b0;
    finish     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // done_q high means the previous drain finished this cycle; ignore start.
        if (start && !done_q) begin
          if (num_words == '0) begin
            zero_start = 1'b1;
          end else begin
            accept     = 1'b1;
            issue      = 1'b1;
            issue_addr = start_addr;
            issue_last = (num_words == CNT_ONE);
            state_d    = S_RUN;
          end
        end
      end
      S_RUN: begin
        if ((issued_q < num_q) && credit_ok) begin
          issue      = 1'b1;
          issue_addr = start_addr_q + issued_q[ADDR_WIDTH-1:0];
          issue_last = ((issued_q + CNT_ONE) == num_q);
        end
        if ((issued_q == num_q) || (issue && issue_last)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (pop && head_last) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_addr_q <= '0;
      num_q        <= '0;
      issued_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_cen_q    <= MEM_INACTIVE;
      mem_addr_q   <= '0;
      rd_last_q    <= 1'b0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      inflight_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= zero_start || finish;

      if (accept) begin
        start_addr_q <= start_addr;
        num_q        <= num_words;
        issued_q     <= CNT_ONE;
        busy_q       <= 1'b1;
      end else if (issue) begin
        issued_q <= issued_q + CNT_ONE;
      end
      if (finish) busy_q <= 1'b0;

      mem_cen_q <= issue ? MEM_ACTIVE : MEM_INACTIVE;
      if (issue) begin
        mem_addr_q <= issue_addr;
        rd_last_q  <= issue_last;
      end

      pend_q      <= (mem_cen_q == MEM_ACTIVE);
      pend_last_q <= rd_last_q;

      case ({issue, pend_q})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign mem_cen  = mem_cen_q;
  assign mem_wen  = MEM_INACTIVE;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef OUTMEM_READER_CSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else if (accept || zero_start) begin
      csum_q <= '0;
    end else if (pop) begin
      csum_q <= csum_q ^ out_data;
    end
  end

  assign out_csum = csum_q;
`endif

endmodule

// File: doc/outmem_reader.md
# outmem_reader

Drains the CNN output memory through its read port (port B) after a convolution pass and streams the stored 64-bit result words to a downstream consumer over a valid/ready handshake. It sits beside the CNN top level. It takes over the port-B address, chip-enable and write-enable lines, so the controller's port-A writes and this block's reads never conflict. It absorbs the memory's one-cycle read latency and downstream backpressure with a small credit-managed FIFO, and sustains one word per cycle when the consumer is always ready.

## Interface
- ADDR_WIDTH, 10, output-memory address width; the memory holds 2^ADDR_WIDTH words.
- DATA_WIDTH, 64, output-memory word width.
- FIFO_DEPTH, 4, skid FIFO entries; must be a power of two and at least 3.
- clk  in  1  the single clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that starts a drain; sampled only in IDLE.
- start_addr  in  ADDR_WIDTH  address of the first word to read.
- num_words  in  ADDR_WIDTH+1  number of words to read, 0 to 2^ADDR_WIDTH.
- mem_cen  out  1  port-B chip enable, active-low.
- mem_wen  out  1  port-B write enable, active-low; held at 1 (read only).
- mem_addr  out  ADDR_WIDTH  port-B address.
- mem_q  in  DATA_WIDTH  port-B read data, valid one cycle after the address edge.
- out_valid  out  1  output word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_WIDTH  output word.
- out_last  out  1  marks the final word of the drain.
- busy  out  1  drain in progress.
- done  out  1  one-cycle pulse when the drain completes.
- out_csum  out  DATA_WIDTH  XOR checksum of the delivered words; present only with `OUTMEM_READER_CSUM_EN`.

## Operation
- **States:** IDLE, RUN, FLUSH.
- **IDLE:**
  - On start with num_words ≠ 0, latch the parameters, set busy and go to RUN.
  - On start with num_words = 0, pulse done for one cycle, leave busy low and stay in IDLE.
- **RUN:**
  - Issue a read in any cycle where issued < num_words and fifo_count + inflight < FIFO_DEPTH.
  - A same-cycle pop is not credited.
  - Each read drives mem_cen=0 and mem_addr=(start_addr+issued) mod 2^ADDR_WIDTH; the address wraps.
  - The data returned by each read is written into the FIFO.
  - When the final read has been issued, go to FLUSH.
- **FLUSH:** when the last word completes its handshake (out_valid & out_ready, with out_last=1), pulse done, clear busy and go to IDLE.
- **Output:** out_valid = FIFO not empty. out_data and out_last come from the FIFO head. out_last is computed when the read is issued.
- **Backpressure:** holding out_ready=0 freezes out_data and out_last. No word is ever dropped or duplicated.
- **start while busy:** ignored, including a start in the same cycle as done.
- **Reset:** takes effect at any time, including mid-drain; reads still in flight are discarded. Reset values:
  - state=IDLE, FIFO empty, busy=0, done=0.
  - mem_cen=1, mem_wen=1, mem_addr=0.
  - out_valid=0, out_last=0, out_data=0, out_csum=0.

## Timing
- mem_cen and mem_addr are registered outputs.
- **First word:** start is sampled at edge E.
  - The first address is on the memory pins from E.
  - The memory samples it at E+1.
  - The FIFO captures mem_q at E+2.
  - out_valid rises after E+2, giving a 2-cycle start-to-valid latency.
- **Throughput:** with out_ready held high, one word per cycle; N words take N+2 cycles from start to the last handshake.
- **done:** asserted in the cycle after the last handshake edge; busy falls on the same edge.
- **Idle cycles:** mem_cen=1 whenever no read is issued.

## Configuration
- **`OUTMEM_READER_CSUM_EN` defined:**
  - out_csum clears to 0 on an accepted start.
  - It XORs in out_data on every handshake.
  - It holds its final value from done until the next start.
- **Not defined:** the out_csum port and its register are absent; all other behaviour is identical.

## Structure
- **Shared package `cnn_pkg`:** the state enum (IDLE/RUN/FLUSH), the DATA_WIDTH=64 and ADDR_WIDTH=10 defaults, and the mem active-low constants.
- **Sub-module `sync_fifo`:** holds the data+last entries, exposes count, empty and full, and clears on reset.
- **Top level:** the FSM, issue counter, inflight counter (0–2) and checksum stay here.

## Test plan
- Start at addr 0x010 with N=8, out_ready=1, memory word[i]=i → 8 beats of 0x10..0x17 on consecutive cycles, out_last on the 8th, done 11 cycles after start. With the macro, out_csum=0x10^…^0x17=0x0.
- Start at addr 0x3FE with N=4 → reads 0x3FE, 0x3FF, 0x000, 0x001 in order (wrap).
- N=6 with out_ready toggling 1,0,0,1… → data stable while stalled, all 6 words delivered in order, inflight+count never exceeds FIFO_DEPTH.
- N=0 start → done pulse one cycle later, busy stays 0, mem_cen stays 1, no out_valid.
- Second start pulse during RUN → ignored; word count and done unaffected.
- Reset asserted after the 3rd beat of N=16 → all outputs take their reset values immediately. A new start with N=2 then delivers exactly 2 words.
